// File: rtl/clock_pkg.sv
// Shared BCD widths, digit limits and load validation for the time-of-day counter.
package clock_pkg;

    localparam int DIG_W   = 4;
    localparam int SEC10_W = 3;
    localparam int MIN10_W = 3;
    localparam int HR10_W  = 2;

    localparam logic [DIG_W-1:0]   DIG_MAX            = 4'd9;
    localparam logic [SEC10_W-1:0] SEC_TENS_MAX       = 3'd5;
    localparam logic [HR10_W-1:0]  HR_TENS_MAX        = 2'd2;
    localparam logic [DIG_W-1:0]   HR_UNITS_MAX_AT_20 = 4'd3;

    localparam int DEFAULT_CLK_DIV = 50_000_000;

    // Minutes tens share the 0..5 range with seconds tens.
    function automatic logic bcd_time_valid(
        input logic [DIG_W-1:0]   s1,
        input logic [SEC10_W-1:0] s10,
        input logic [DIG_W-1:0]   m1,
        input logic [MIN10_W-1:0] m10,
        input logic [DIG_W-1:0]   h1,
        input logic [HR10_W-1:0]  h10
    );
        logic ok;
        ok = (s1 <= DIG_MAX) && (s10 <= SEC_TENS_MAX) &&
             (m1 <= DIG_MAX) && (m10 <= SEC_TENS_MAX) &&
             (h1 <= DIG_MAX) && (h10 <= HR_TENS_MAX);
        if ((h10 == HR_TENS_MAX) && (h1 > HR_UNITS_MAX_AT_20)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit counting 0..limit; wrap is the combinational carry into the next digit.
module bcd_digit #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] STATIC_MAX = W'(N - 1);

    logic [W-1:0] limit;
    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // A run-time max can only tighten the static modulus, never widen it.
    assign limit = (max_val < STATIC_MAX) ? max_val : STATIC_MAX;
    assign wrap  = inc && (value_q == limit);
    assign value = value_q;

    // Out-of-range values fall back to 0 on the next increment without a carry.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            value_d = (value_q >= limit) ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD timekeeper driven by a 1 Hz prescaler, with validated load and midnight day_tick.
module time_of_day_counter
    import clock_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int PRESC_W = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    input  logic               load_en,
    input  logic [DIG_W-1:0]   load_sec_1,
    input  logic [SEC10_W-1:0] load_sec_10,
    input  logic [DIG_W-1:0]   load_min_1,
    input  logic [MIN10_W-1:0] load_min_10,
    input  logic [DIG_W-1:0]   load_hour_1,
    input  logic [HR10_W-1:0]  load_hour_10,
    output logic [DIG_W-1:0]   sec_1,
    output logic [SEC10_W-1:0] sec_10,
    output logic [DIG_W-1:0]   min_1,
    output logic [MIN10_W-1:0] min_10,
    output logic [DIG_W-1:0]   hour_1,
    output logic [HR10_W-1:0]  hour_10,
    output logic               sec_tick,
    output logic               day_tick,
    output logic               load_ack,
    output logic               load_err
);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sec_tick_q, sec_tick_d;
    logic               day_tick_q, day_tick_d;
    logic               load_ack_q, load_ack_d;
    logic               load_err_q, load_err_d;

    logic               tick;
    logic               load_valid;
    logic               load_accept;
    logic               advance;
    logic               wrap_s1, wrap_s10, wrap_m1, wrap_m10, wrap_h1, wrap_h10;
    logic [DIG_W-1:0]   hour_1_max;

    assign tick        = run_en && (presc_q == PRESC_LAST);
    assign load_valid  = bcd_time_valid(load_sec_1, load_sec_10, load_min_1,
                                        load_min_10, load_hour_1, load_hour_10);
    assign load_accept = load_en && load_valid;
    // An accepted load swallows a coincident tick; a rejected one does not.
    assign advance     = tick && !load_accept;
    assign hour_1_max  = (hour_10 == HR_TENS_MAX) ? HR_UNITS_MAX_AT_20 : DIG_MAX;

    always_comb begin
        presc_d = presc_q;
        if (load_accept || tick) begin
            presc_d = '0;
        end else if (run_en) begin
            presc_d = presc_q + 1'b1;
        end
        sec_tick_d = advance;
        day_tick_d = wrap_h10;
        load_ack_d = load_accept;
        load_err_d = load_en && !load_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_ack_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            load_ack_q <= load_ack_d;
            load_err_q <= load_err_d;
        end
    end

    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;
    assign load_ack = load_ack_q;
    assign load_err = load_err_q;

    bcd_digit #(.N(10), .W(DIG_W)) u_sec_1 (
        .clk(clk), .rst_n(rst_n), .inc(advance), .load(load_accept),
        .load_val(load_sec_1), .max_val('1), .value(sec_1), .wrap(wrap_s1)
    );

    bcd_digit #(.N(6), .W(SEC10_W)) u_sec_10 (
        .clk(clk), .rst_n(rst_n), .inc(wrap_s1), .load(load_accept),
        .load_val(load_sec_10), .max_val('1), .value(sec_10), .wrap(wrap_s10)
    );

    bcd_digit #(.N(10), .W(DIG_W)) u_min_1 (
        .clk(clk), .rst_n(rst_n), .inc(wrap_s10), .load(load_accept),
        .load_val(load_min_1), .max_val('1), .value(min_1), .wrap(wrap_m1)
    );

    bcd_digit #(.N(6), .W(MIN10_W)) u_min_10 (
        .clk(clk), .rst_n(rst_n), .inc(wrap_m1), .load(load_accept),
        .load_val(load_min_10), .max_val('1), .value(min_10), .wrap(wrap_m10)
    );

    bcd_digit #(.N(10), .W(DIG_W)) u_hour_1 (
        .clk(clk), .rst_n(rst_n), .inc(wrap_m10), .load(load_accept),
        .load_val(load_hour_1), .max_val(hour_1_max), .value(hour_1), .wrap(wrap_h1)
    );

    bcd_digit #(.N(3), .W(HR10_W)) u_hour_10 (
        .clk(clk), .rst_n(rst_n), .inc(wrap_h1), .load(load_accept),
        .load_val(load_hour_10), .max_val('1), .value(hour_10), .wrap(wrap_h10)
    );

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench: a seconds-of-day model predicts each output pulse; a monitor checks them as they appear.
module tb_time_of_day_counter;

    localparam int CLK_DIV  = 4;
    localparam int PRESC_W  = 3;
    localparam int DAY_SECS = 86400;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run_en;
    logic       load_en;
    logic [3:0] load_sec_1;
    logic [2:0] load_sec_10;
    logic [3:0] load_min_1;
    logic [2:0] load_min_10;
    logic [3:0] load_hour_1;
    logic [1:0] load_hour_10;
    logic [3:0] sec_1;
    logic [2:0] sec_10;
    logic [3:0] min_1;
    logic [2:0] min_10;
    logic [3:0] hour_1;
    logic [1:0] hour_10;
    logic       sec_tick;
    logic       day_tick;
    logic       load_ack;
    logic       load_err;
    logic [23:0] dut_vec;

    typedef struct {
        int          cyc;
        logic [23:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_secs   = 0;
    int   m_presc  = 0;

    time_of_day_counter #(.CLK_DIV(CLK_DIV), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .load_en(load_en),
        .load_sec_1(load_sec_1), .load_sec_10(load_sec_10),
        .load_min_1(load_min_1), .load_min_10(load_min_10),
        .load_hour_1(load_hour_1), .load_hour_10(load_hour_10),
        .sec_1(sec_1), .sec_10(sec_10), .min_1(min_1), .min_10(min_10),
        .hour_1(hour_1), .hour_10(hour_10),
        .sec_tick(sec_tick), .day_tick(day_tick),
        .load_ack(load_ack), .load_err(load_err)
    );

    assign dut_vec = {hour_10, hour_1, min_10, min_1, sec_10, sec_1,
                      sec_tick, day_tick, load_ack, load_err};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] time_vec(input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] pack_exp(input int secs, input bit st, input bit dt,
                                             input bit ack, input bit err);
        return {time_vec(secs), st, dt, ack, err};
    endfunction

    // Predicts the outcome of the coming rising edge from the inputs being applied now.
    task automatic model_step(input bit runv, input bit loadv, input int h10, input int h1,
                              input int m10, input int m1, input int s10, input int s1);
        bit tick, valid, day;
        int hrs, mins, secs_f;
        tick   = runv && (m_presc == CLK_DIV - 1);
        hrs    = 10 * h10 + h1;
        mins   = 10 * m10 + m1;
        secs_f = 10 * s10 + s1;
        valid  = (h1 < 10) && (m1 < 10) && (s1 < 10) && (hrs < 24) && (mins < 60) && (secs_f < 60);
        day    = 1'b0;
        if (loadv && valid) begin
            m_secs  = hrs * 3600 + mins * 60 + secs_f;
            m_presc = 0;
            exp_q.push_back('{cyc + 1, pack_exp(m_secs, 1'b0, 1'b0, 1'b1, 1'b0)});
        end else begin
            if (runv) m_presc = (m_presc + 1) % CLK_DIV;
            if (tick) begin
                m_secs = (m_secs + 1) % DAY_SECS;
                day    = (m_secs == 0);
            end
            if (tick || loadv)
                exp_q.push_back('{cyc + 1, pack_exp(m_secs, tick, day, 1'b0, loadv)});
        end
    endtask

    task automatic applyStimulus(input bit runv, input bit loadv, input int h10, input int h1,
                                 input int m10, input int m1, input int s10, input int s1);
        @(negedge clk);
        run_en       = runv;
        load_en      = loadv;
        load_hour_10 = 2'(h10);
        load_hour_1  = 4'(h1);
        load_min_10  = 3'(m10);
        load_min_1   = 4'(m1);
        load_sec_10  = 3'(s10);
        load_sec_1   = 4'(s1);
        model_step(runv, loadv, h10, h1, m10, m1, s10, s1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n, input bit runv);
        repeat (n) applyStimulus(runv, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alignTick();
        int guard = 0;
        while (m_presc != CLK_DIV - 1 && guard < 2 * CLK_DIV) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
            guard++;
        end
    endtask

    // Waits for the edge the model already predicted, then compares the time digits.
    task automatic settleCheckTime(input string name);
        logic [23:0] snap;
        @(posedge clk);
        #1;
        snap = dut_vec;
        checkOutput(name, 32'(snap[23:4]), 32'(time_vec(m_secs)));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL missed_pulse: nothing at cycle %0d, expected %0h",
                         exp_q[0].cyc, exp_q[0].vec);
                void'(exp_q.pop_front());
            end
            if (sec_tick || day_tick || load_ack || load_err) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_pulse: got %0h at cycle %0d, expected none",
                             dut_vec, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== dut_vec) begin
                        n_fail++;
                        $display("[TB] FAIL pulse_event: got %0h at cycle %0d, expected %0h at cycle %0d",
                                 dut_vec, cyc, e.vec, e.cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        run_en = 1'b0;
        load_en = 1'b0;
        load_hour_10 = '0; load_hour_1 = '0; load_min_10 = '0;
        load_min_1 = '0; load_sec_10 = '0; load_sec_1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(dut_vec), 32'h0);
        #1 rst_n = 1'b1;

        $display("[TB] first second after reset");
        idle(4, 1'b1);
        settleCheckTime("first_second");

        $display("[TB] cascade rollovers");
        applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 5, 9);
        idle(4, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, 0, 5, 9, 5, 9);
        idle(4, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, 9, 5, 9, 5, 9);
        idle(4, 1'b1);
        settleCheckTime("hour_tens_carry");

        $display("[TB] midnight rollover");
        applyStimulus(1'b1, 1'b1, 2, 3, 5, 9, 5, 9);
        idle(5, 1'b1);

        $display("[TB] load validation");
        applyStimulus(1'b1, 1'b1, 2, 4, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1, 9, 6, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1, 2, 0, 0, 5, 10);
        settleCheckTime("invalid_loads_keep_time");
        applyStimulus(1'b1, 1'b1, 2, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 2, 3, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
        idle(2, 1'b1);

        $display("[TB] load and tick collide");
        alignTick();
        applyStimulus(1'b1, 1'b1, 0, 5, 0, 5, 0, 5);
        idle(5, 1'b1);
        alignTick();
        applyStimulus(1'b1, 1'b1, 3, 0, 0, 0, 0, 0);
        idle(2, 1'b1);

        $display("[TB] pause and load while paused");
        idle(20, 1'b0);
        settleCheckTime("paused_time_frozen");
        applyStimulus(1'b0, 1'b1, 1, 7, 4, 2, 3, 1);
        idle(6, 1'b0);
        idle(6, 1'b1);

        $display("[TB] reset mid-operation");
        alignTick();
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        m_secs = 0;
        m_presc = 0;
        #1;
        checkOutput("reset_mid_count", 32'(dut_vec), 32'h0);
        #1 rst_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 500; i++) begin
            int r;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'b1,
                              $urandom_range(0, 3), $urandom_range(0, 15),
                              $urandom_range(0, 7), $urandom_range(0, 15),
                              $urandom_range(0, 7), $urandom_range(0, 15));
            end else if (r == 1) begin
                int h;
                h = $urandom_range(0, 23);
                applyStimulus(1'b1, 1'b1, h / 10, h % 10, 5, 9, 5, $urandom_range(7, 9));
            end else begin
                applyStimulus(1'($urandom_range(0, 7) != 0), 1'b0, 0, 0, 0, 0, 0, 0);
            end
        end

        idle(3, 1'b0);
        settleCheckTime("final_time");
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Seconds/minutes/hours timekeeper for the century clock. It sits directly upstream of the day/month/year date stage.
- Divides the system clock down to a 1 Hz tick and keeps HH:MM:SS in BCD in 24-hour format.
- Emits a one-cycle day_tick at the 23:59:59 -> 00:00:00 rollover; the date stage consumes it.
- Supports a validated time-load request and a run/pause control.

Parameters:
- CLK_DIV, 50_000_000: system clock cycles per second tick; legal range >= 2.
- PRESC_W, 26: prescaler width; must satisfy 2^PRESC_W >= CLK_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_en  in  1  1 = prescaler advances; 0 = prescaler and time frozen.
- load_en  in  1  one-cycle request to load the time from load_* inputs.
- load_sec_1  in  4  BCD seconds units.
- load_sec_10  in  3  BCD seconds tens.
- load_min_1  in  4  BCD minutes units.
- load_min_10  in  3  BCD minutes tens.
- load_hour_1  in  4  BCD hours units.
- load_hour_10  in  2  BCD hours tens.
- sec_1  out  4  BCD seconds units.
- sec_10  out  3  BCD seconds tens.
- min_1  out  4  BCD minutes units.
- min_10  out  3  BCD minutes tens.
- hour_1  out  4  BCD hours units.
- hour_10  out  2  BCD hours tens.
- sec_tick  out  1  one-cycle pulse per elapsed second.
- day_tick  out  1  one-cycle pulse on midnight rollover.
- load_ack  out  1  one-cycle pulse: load accepted.
- load_err  out  1  one-cycle pulse: load rejected.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all time outputs 0 (00:00:00); prescaler 0; sec_tick, day_tick, load_ack, load_err all 0.
- Prescaler:
  - While run_en=1, counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and an internal tick is asserted in the same cycle.
  - While run_en=0 it holds its value and no tick is generated.
- Tick update (all outputs registered):
  - On the cycle after the tick, the time has advanced by one second and sec_tick=1 for exactly one cycle.
  - The first second after reset appears at clock edge CLK_DIV.
- Cascade:
  - sec_1 counts 0..9, wrapping into sec_10 (0..5).
  - The sec 59->00 wrap advances min_1 (0..9), which wraps into min_10 (0..5).
  - The min 59->00 wrap advances the hour.
  - Hour counts 00..23; hour_1 wraps at 9 except when hour_10=2, where it wraps at 3.
- Midnight: the 23:59:59 tick produces 00:00:00, with day_tick=1 and sec_tick=1 in the same cycle.
- Load validation: a load is valid iff all of the following hold:
  - sec_1<=9, sec_10<=5, min_1<=9, min_10<=5, hour_1<=9;
  - hour_10<=2;
  - if hour_10=2, then hour_1<=3.
- Valid load:
  - Next cycle the outputs equal the loaded value, the prescaler is cleared to 0 and load_ack=1.
  - sec_tick and day_tick stay 0 in that cycle, even when loading 00:00:00.
- Invalid load: time and prescaler unchanged; load_err=1 for one cycle.
- Simultaneous load_en and tick:
  - The load has priority and that tick is discarded (no sec_tick, no day_tick).
  - An invalid load in the same cycle as a tick does not suppress the tick; the time advances normally and load_err=1.
- Load while paused: load_en is honoured regardless of run_en.
- Reset mid-operation: asynchronous return to the reset values; any pending tick or pulse is cleared.
- Unreachable BCD states (for example a digit >9 after an SEU) self-correct to 0 on the next tick for that digit.

Decomposition:
- Package clock_pkg holds:
  - BCD width constants (DIG_W=4, SEC10_W=3, MIN10_W=3, HR10_W=2);
  - limits SEC_TENS_MAX=5, HR_TENS_MAX=2, HR_UNITS_MAX_AT_20=3;
  - default CLK_DIV.
- One sub-module, bcd_digit: a mod-N BCD digit counter with parameter N, inputs inc and load with value, and output wrap (combinational carry).
  - Instantiated six times; the hour-units instance receives a dynamic max derived from hour_10.

Test Plan (CLK_DIV=4):
- Reset release -> outputs 00:00:00; first sec_tick at edge 4; time 00:00:01.
- Load 00:00:59 (ack) then one tick -> 00:01:00; 00:59:59 + tick -> 01:00:00; 09:59:59 + tick -> 10:00:00.
- Load 23:59:59, run to tick -> 00:00:00 with day_tick=1 exactly one cycle together with sec_tick.
- Loads 24:00:00, 19:60:00, 12:00:5A -> load_err=1, time unchanged; load 20:00:00 and 23:00:00 -> load_ack=1.
- load_en asserted on the tick cycle with value 05:05:05 -> next time 05:05:05, no sec_tick; prescaler restarts, so the next tick comes 4 cycles later.
- run_en=0 for 20 cycles -> no ticks and time frozen; assert rst_n=0 mid-count -> immediate 00:00:00, pulses 0.
